ahb_lite_mem_slave: RTL and testbench
=====================================

Name: ahb_lite_mem_slave

Overview:
Parametrised AHB-Lite single-slave memory, next generation of the fixed 8-bit-address / 32-bit-data memory the bench targets. Configurable width, depth and wait states. Adds byte-lane writes, pipelined address/data phases and a two-cycle ERROR response for illegal transfers. Sits directly behind the AHB-Lite master; with a single slave, HREADY is driven from this block's HREADYOUT.

Parameters:
ADDR_W, 8, HADDR width in bits.
DATA_W, 32, HWDATA/HRDATA width; legal values 32 or 64.
DEPTH_WORDS, 64, number of DATA_W-wide words; must be ≤ 2^(ADDR_W - log2(DATA_W/8)).
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; legal range 0..7.

Ports:
HCLK  in  1  clock; all logic on the rising edge.
HRESET  in  1  reset; asynchronous, active-low.
HSEL  in  1  slave select.
HADDR  in  ADDR_W  byte address.
HWRITE  in  1  1 = write, 0 = read.
HSIZE  in  3  transfer size, 2^HSIZE bytes.
HBURST  in  3  burst type; accepted, no functional effect.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HPROT  in  4  protection; accepted, ignored.
HWDATA  in  DATA_W  write data, valid in the data phase.
HREADY  in  1  bus ready; previous transfer complete.
HRDATA  out  DATA_W  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESET=0, asynchronous): state IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; captured address-phase registers cleared; any pending write discarded. Memory contents are not reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1] at a rising edge. Captured: HADDR, HWRITE, HSIZE.
- IDLE/BUSY or HSEL=0 with HREADY=1: next cycle HREADYOUT=1, HRESP=0, no access.
- Index and lane rules:
  - word index = HADDR[ADDR_W-1 : log2(DATA_W/8)].
  - lane offset = low log2(DATA_W/8) bits.
  - Little-endian byte lanes: byte k of HWDATA/HRDATA maps to address offset k.
- Error checks, evaluated on captured values:
  - HSIZE > log2(DATA_W/8);
  - HADDR not aligned to 2^HSIZE;
  - word index ≥ DEPTH_WORDS.
  Any one of these gives ERROR.
- FSM states:
  - IDLE: waiting for a transfer.
  - WAIT: down-counter loaded with WAIT_STATES; HREADYOUT=0, HRESP=0.
  - DONE: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Accepted legal transfer → WAIT if WAIT_STATES>0, else DONE.
  - WAIT → DONE when count reaches 0.
  - Accepted illegal transfer → ERR1 → ERR2.
  - DONE/ERR2 → IDLE, or straight back into a new transfer if one is accepted in the same cycle (back-to-back pipelining, no bubble).
- Write: HWDATA enabled lanes are committed at the rising edge ending DONE. Disabled lanes are unchanged. An errored transfer never writes.
- Read: HRDATA is valid during DONE; all DATA_W bits come from the addressed word. Outside DONE, HRDATA holds its last value.
- Write then read to the same word back-to-back: the read returns the newly written bytes (forwarded, no stale data).
- Wait counter width: 3 bits. Latency per OKAY transfer = WAIT_STATES+1 data-phase cycles. ERROR is always 2 cycles.
- Reset asserted mid-WAIT or mid-ERR: immediate return to reset values; transfer dropped.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS codes, HRESP codes and HSIZE codes (BYTE/HALF/WORD/DWORD);
  - FSM state enum;
  - function computing byte-lane enables from HSIZE and lane offset.
- One sub-module ahb_lite_mem_array:
  - DEPTH_WORDS × DATA_W storage;
  - per-byte write enable, synchronous write, combinational read.

Test Plan:
1. Reset, WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 → HRDATA=0xDEADBEEF in the data-phase cycle, HREADYOUT=1, HRESP=0.
2. Byte write 0xAA @0x11 over word 0x00000000 @0x10, then word read @0x10 → 0x0000AA00.
3. WAIT_STATES=2: single read → HREADYOUT low exactly 2 cycles, then high with data.
4. Illegal transfers, each separately → ERR1/ERR2 sequence (HREADYOUT 0 then 1, HRESP 1 both cycles), memory unchanged:
   - half-word @0x03 (unaligned);
   - address 0xFC with DEPTH_WORDS=32 (out of range);
   - HSIZE=3 with DATA_W=32 (oversize).
5. INCR4 burst writes @0x20..0x2C, then back-to-back reads → 4 OKAY beats with no idle bubble, each data matching. BUSY inserted mid-burst → zero-wait OKAY, no access.
6. Assert HRESET low during a WAIT cycle of a write → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; a subsequent read shows the write was not committed.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_pkg
//  Description : Shared AHB-Lite bus codes, slave FSM state type and the
//                byte-lane enable helper used by the memory slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_lite_pkg;

    // HTRANS encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    // HSIZE encodings (2^HSIZE bytes)
    localparam logic [2:0] c_HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF  = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD  = 3'd2;
    localparam logic [2:0] c_HSIZE_DWORD = 3'd3;

    // Data-phase state of the slave
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // no data phase in progress
        ST_WAIT = 3'd1,   // inserting wait states
        ST_DONE = 3'd2,   // OKAY data phase completes this cycle
        ST_ERR1 = 3'd3,   // first ERROR cycle, HREADYOUT low
        ST_ERR2 = 3'd4    // second ERROR cycle, HREADYOUT high
    } state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            c_HTRANS_NONSEQ,
            c_HTRANS_SEQ:    active = 1'b1;
            c_HTRANS_IDLE,
            c_HTRANS_BUSY:   active = 1'b0;
            default:         active = 1'b0;
        endcase
        return active;
    endfunction

    // Byte-lane enables for a transfer of the given size starting at the
    // given lane offset within the data word (little-endian: lane k holds
    // the byte at offset k). Supports up to 8 lanes.
    function automatic logic [7:0] lane_enables(input logic [2:0] size,
                                                input logic [2:0] offset);
        logic [7:0] mask;
        case (size)
            c_HSIZE_BYTE:  mask = 8'h01;
            c_HSIZE_HALF:  mask = 8'h03;
            c_HSIZE_WORD:  mask = 8'h0F;
            c_HSIZE_DWORD: mask = 8'hFF;
            default:       mask = 8'h00;
        endcase
        return mask << offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_mem_array
//  Description : DEPTH_WORDS x DATA_W storage with per-byte write enables,
//                synchronous write and combinational read. No reset: memory
//                contents survive bus reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_mem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int c_NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Commit only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < c_NBYTES; k++) begin
                if (i_be[k]) begin
                    r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_mem_slave
//  Description : Parametrised AHB-Lite single-slave memory. Pipelined address
//                and data phases, configurable wait states, byte-lane writes
//                and a two-cycle ERROR response for illegal transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [ADDR_W-1:0]   HADDR,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic [1:0]          HTRANS,
    input  logic [3:0]          HPROT,
    input  logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADY,
    output logic [DATA_W-1:0]   HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP
);

    localparam int         c_NBYTES    = DATA_W / 8;
    localparam int         c_LANE_BITS = $clog2(c_NBYTES);
    localparam int         c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] c_LANE_MASK = 3'(c_NBYTES - 1);
    localparam logic [2:0] c_WAIT_LOAD = 3'(WAIT_STATES);

    // Registered state
    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;

    // Address-phase decode
    logic                w_slave_ready;
    logic                w_accept;
    logic [2:0]          w_align_mask;
    logic                w_oversize;
    logic                w_misaligned;
    logic [31:0]         w_word_idx;
    logic                w_out_of_range;
    logic                w_illegal;

    // Data-phase / memory interface
    logic [2:0]          w_lane_off;
    logic [7:0]          w_lanes8;
    logic [c_NBYTES-1:0] w_be;
    logic [c_IDX_W-1:0]  w_mem_idx;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_rd_live;

    // HBURST/HPROT carry no function here; the lane helper is 8 lanes wide.
    logic                w_unused;
    assign w_unused = ^{HBURST, HPROT, w_lanes8};

    // The slave can take a new address phase only when its own data phase
    // is finishing (or idle); in WAIT/ERR1 the master must hold the bus.
    assign w_slave_ready = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                           (state_q == ST_ERR2);
    assign w_accept      = HSEL && HREADY && htrans_active(HTRANS) && w_slave_ready;

    // Legality checks. They are evaluated on the address-phase inputs at the
    // accepting edge, which are exactly the values being captured there, so
    // the ERR path can be entered without an extra decode cycle.
    assign w_align_mask   = (3'b001 << HSIZE) - 3'b001;
    assign w_oversize     = HSIZE > 3'(c_LANE_BITS);
    assign w_misaligned   = (3'(HADDR) & w_align_mask) != 3'b000;
    assign w_word_idx     = 32'(HADDR >> c_LANE_BITS);
    assign w_out_of_range = w_word_idx >= 32'(DEPTH_WORDS);
    assign w_illegal      = w_oversize || w_misaligned || w_out_of_range;

    // Next-state, wait counter and address-phase capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR1:          state_d = ST_ERR2;
            ST_DONE, ST_ERR2: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase

        // A transfer accepted while DONE/ERR2 completes overrides the return
        // to IDLE, giving back-to-back data phases with no bubble.
        if (w_accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            size_d  = HSIZE;
            if (w_illegal) begin
                state_d = ST_ERR1;
            end else if (c_WAIT_LOAD != 3'd0) begin
                state_d = ST_WAIT;
                cnt_d   = c_WAIT_LOAD;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    // State and capture registers; reset drops any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Memory access uses the captured address. Writes commit on the edge
    // that ends DONE, so a read data phase that follows reads the array
    // combinationally and already sees the new bytes.
    assign w_lane_off = 3'(addr_q) & c_LANE_MASK;
    assign w_lanes8   = lane_enables(size_q, w_lane_off);
    assign w_be       = w_lanes8[c_NBYTES-1:0];
    assign w_mem_idx  = c_IDX_W'(addr_q >> c_LANE_BITS);
    assign w_mem_we   = (state_q == ST_DONE) && write_q;

    ahb_lite_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_mem (
        .clk     (HCLK),
        .i_we    (w_mem_we),
        .i_be    (w_be),
        .i_idx   (w_mem_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_mem_rdata)
    );

    // Read data is live during a read DONE and held everywhere else.
    assign w_rd_live = (state_q == ST_DONE) && !write_q;
    assign HRDATA    = w_rd_live ? w_mem_rdata : hrdata_q;
    assign hrdata_d  = HRDATA;

    // Holding register for HRDATA outside the read data phase.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            hrdata_q <= '0;
        end else begin
            hrdata_q <= hrdata_d;
        end
    end

    assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ?
                       c_HRESP_ERROR : c_HRESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_mem_slave
//  Description : Self-checking bench for ahb_lite_mem_slave. Two instances
//                share the bus: u_dut0 (no wait states, 32 words) and u_dut1
//                (2 wait states, 64 words), each selected by its own HSEL.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_mem_slave;

    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        HSEL0 = 1'b0;
    logic        HSEL1 = 1'b0;
    logic [7:0]  HADDR = 8'h0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [2:0]  HBURST = 3'd0;
    logic [1:0]  HTRANS = 2'd0;
    logic [3:0]  HPROT = 4'h3;
    logic [31:0] HWDATA = 32'h0;
    logic [31:0] HRDATA0, HRDATA1;
    logic        HREADYOUT0, HREADYOUT1;
    logic        HRESP0, HRESP1;

    int checks = 0;
    int failures = 0;

    // Byte-addressed reference memory per instance.
    logic [7:0] mdl [2][256];
    int depth_w [2] = '{32, 64};
    int ws      [2] = '{0, 2};
    xfer_t seq [$];
    xfer_t tbl [23];

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_slave #(
        .ADDR_W(8), .DATA_W(32), .DEPTH_WORDS(32), .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL0), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADYOUT0),
        .HRDATA(HRDATA0), .HREADYOUT(HREADYOUT0), .HRESP(HRESP0)
    );

    ahb_lite_mem_slave #(
        .ADDR_W(8), .DATA_W(32), .DEPTH_WORDS(64), .WAIT_STATES(2)
    ) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL1), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADYOUT1),
        .HRDATA(HRDATA1), .HREADYOUT(HREADYOUT1), .HRESP(HRESP1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_sel(input int d, input logic v);
        HSEL0 = (d == 0) && v;
        HSEL1 = (d == 1) && v;
    endtask

    // Reference behaviour: legality, little-endian byte placement, whole-word
    // reads. Transfers complete in order, so applying them in sequence order
    // yields the expected read data including write-then-read forwarding.
    function automatic xfer_t model_xfer(input int d, input xfer_t x);
        xfer_t y;
        int n;
        int a;
        y = x;
        y.exp_err = 1'b0;
        y.chk_rd  = 1'b0;
        y.exp_rd  = 32'h0;
        if (x.trans < 2'd2) return y;
        n = 1 << x.size;
        if (x.size > 3'd2 || (int'(x.addr) % n) != 0 || (int'(x.addr) / 4) >= depth_w[d]) begin
            y.exp_err = 1'b1;
            return y;
        end
        if (x.wr) begin
            for (int j = 0; j < n; j++) begin
                a = int'(x.addr) + j;
                mdl[d][a] = 8'(x.wdata >> (8 * (a % 4)));
            end
        end else begin
            a = int'(x.addr) & ~3;
            y.exp_rd = {mdl[d][a+3], mdl[d][a+2], mdl[d][a+1], mdl[d][a]};
            y.chk_rd = 1'b1;
        end
        return y;
    endfunction

    task automatic push(input int d, input logic [1:0] t, input logic w,
                        input logic [2:0] s, input logic [7:0] a, input logic [31:0] wd);
        xfer_t x;
        x.trans = t; x.wr = w; x.size = s; x.addr = a; x.wdata = wd;
        x.exp_err = 1'b0; x.chk_rd = 1'b0; x.exp_rd = 32'h0;
        seq.push_back(model_xfer(d, x));
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Drives seq as a pipelined AHB-Lite master: each item's address phase
    // overlaps the previous item's data phase and is held while HREADY is low.
    task automatic run_seq(input int d);
        int    i;
        bit    pend;
        xfer_t p;
        int    cyc;
        int    need;
        logic  r, s;
        logic [31:0] rd;
        i = 0; pend = 1'b0; cyc = 0; r = 1'b1;
        p = '{default: '0};
        while (i < seq.size() || pend) begin
            if (i < seq.size()) begin
                set_sel(d, seq[i].trans != 2'd0);
                HTRANS = seq[i].trans;
                HWRITE = seq[i].wr;
                HSIZE  = seq[i].size;
                HADDR  = seq[i].addr;
            end else begin
                set_sel(d, 1'b0);
                HTRANS = 2'd0;
            end
            HWDATA = pend ? p.wdata : 32'h0;
            @(negedge HCLK);
            r  = (d == 0) ? HREADYOUT0 : HREADYOUT1;
            s  = (d == 0) ? HRESP0 : HRESP1;
            rd = (d == 0) ? HRDATA0 : HRDATA1;
            if (pend) begin
                cyc++;
                need = (p.trans < 2'd2) ? 1 : (p.exp_err ? 2 : ws[d] + 1);
                chk($sformatf("hreadyout d%0d item%0d cyc%0d", d, i - 1, cyc),
                    32'(r), 32'(cyc >= need));
                chk($sformatf("hresp d%0d item%0d cyc%0d", d, i - 1, cyc),
                    32'(s), 32'(p.exp_err));
                if (r && p.chk_rd) begin
                    chk($sformatf("hrdata d%0d item%0d addr%h", d, i - 1, p.addr), rd, p.exp_rd);
                end
                if (cyc > need + 8) begin
                    failures++;
                    $display("FAIL timeout d%0d item%0d: got no HREADYOUT after %0d cycles, required %0d",
                             d, i - 1, cyc, need);
                    finish_now();
                end
            end
            @(posedge HCLK);
            #1;
            if (!pend || r) begin
                if (i < seq.size()) begin
                    p = seq[i];
                    i++;
                    pend = 1'b1;
                    cyc = 0;
                end else begin
                    pend = 1'b0;
                end
            end
        end
        set_sel(d, 1'b0);
        HTRANS = 2'd0;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got simulation still running, required completion");
        finish_now();
    end

    initial begin
        // Directed vectors for u_dut0 (zero-preloaded, 32 words, no waits).
        // Fields: trans, wr, size, addr, wdata, exp_err, chk_rd, exp_rd
        tbl[0]  = '{2'd2, 1'b1, 3'd2, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{2'd2, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{2'd2, 1'b1, 3'd2, 8'h10, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[3]  = '{2'd2, 1'b1, 3'd0, 8'h11, 32'h7766AA55, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{2'd2, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 1'b1, 32'h0000AA00};
        tbl[5]  = '{2'd2, 1'b1, 3'd1, 8'h03, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{2'd2, 1'b0, 3'd2, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[7]  = '{2'd2, 1'b1, 3'd2, 8'hFC, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{2'd2, 1'b0, 3'd2, 8'h7C, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[9]  = '{2'd2, 1'b0, 3'd3, 8'h18, 32'h0,        1'b1, 1'b0, 32'h0};
        tbl[10] = '{2'd2, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 1'b1, 32'h0000AA00};
        tbl[11] = '{2'd2, 1'b1, 3'd2, 8'h20, 32'h11111111, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{2'd3, 1'b1, 3'd2, 8'h24, 32'h22222222, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{2'd1, 1'b1, 3'd2, 8'h30, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{2'd3, 1'b1, 3'd2, 8'h28, 32'h33333333, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{2'd3, 1'b1, 3'd2, 8'h2C, 32'h44444444, 1'b0, 1'b0, 32'h0};
        tbl[16] = '{2'd2, 1'b0, 3'd2, 8'h20, 32'h0,        1'b0, 1'b1, 32'h11111111};
        tbl[17] = '{2'd3, 1'b0, 3'd2, 8'h24, 32'h0,        1'b0, 1'b1, 32'h22222222};
        tbl[18] = '{2'd3, 1'b0, 3'd2, 8'h28, 32'h0,        1'b0, 1'b1, 32'h33333333};
        tbl[19] = '{2'd3, 1'b0, 3'd2, 8'h2C, 32'h0,        1'b0, 1'b1, 32'h44444444};
        tbl[20] = '{2'd0, 1'b0, 3'd0, 8'h00, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[21] = '{2'd2, 1'b0, 3'd1, 8'h2E, 32'h0,        1'b0, 1'b1, 32'h44444444};
        tbl[22] = '{2'd2, 1'b0, 3'd2, 8'h30, 32'h0,        1'b0, 1'b1, 32'h0};

        // Reset values while HRESET is held low
        #2;
        chk("reset hreadyout0", 32'(HREADYOUT0), 32'h1);
        chk("reset hresp0",     32'(HRESP0),     32'h0);
        chk("reset hrdata0",    HRDATA0,         32'h0);
        chk("reset hreadyout1", 32'(HREADYOUT1), 32'h1);
        chk("reset hresp1",     32'(HRESP1),     32'h0);
        chk("reset hrdata1",    HRDATA1,         32'h0);
        #18;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;

        // Preload both memories to known contents
        seq.delete();
        for (int k = 0; k < 32; k++) push(0, 2'd2, 1'b1, 3'd2, 8'(4 * k), 32'h0);
        run_seq(0);
        seq.delete();
        for (int k = 0; k < 64; k++) push(1, 2'd2, 1'b1, 3'd2, 8'(4 * k), 32'hA5A50000 | 32'(k));
        run_seq(1);

        // Directed table on u_dut0: expectations are the literals above
        HBURST = 3'b011;
        seq.delete();
        for (int k = 0; k < 23; k++) begin
            xfer_t dummy;
            dummy = model_xfer(0, tbl[k]);
            seq.push_back(tbl[k]);
        end
        run_seq(0);
        HBURST = 3'b000;

        // Two-wait-state read on u_dut1: HREADYOUT low for two cycles
        seq.delete();
        push(1, 2'd2, 1'b0, 3'd2, 8'h40, 32'h0);
        run_seq(1);

        // Reset during the WAIT of a write drops the write
        set_sel(1, 1'b1);
        HTRANS = 2'd2; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 8'h40;
        @(posedge HCLK);
        #1;
        set_sel(1, 1'b0);
        HTRANS = 2'd0;
        HWDATA = 32'h12345678;
        @(negedge HCLK);
        chk("mid-wait hreadyout1", 32'(HREADYOUT1), 32'h0);
        #2;
        HRESET = 1'b0;
        #1;
        chk("async reset hreadyout1", 32'(HREADYOUT1), 32'h1);
        chk("async reset hresp1",     32'(HRESP1),     32'h0);
        chk("async reset hrdata1",    HRDATA1,         32'h0);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        seq.delete();
        push(1, 2'd2, 1'b0, 3'd2, 8'h40, 32'h0);
        run_seq(1);

        // Randomised pipelined traffic on both instances
        for (int d = 0; d < 2; d++) begin
            seq.delete();
            for (int n = 0; n < 200; n++) begin
                int          rt;
                logic [1:0]  t;
                logic [2:0]  s;
                logic [7:0]  a;
                rt = $urandom_range(0, 9);
                t  = (rt == 0) ? 2'd0 : (rt == 1) ? 2'd1 : (rt < 6) ? 2'd2 : 2'd3;
                s  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                a  = 8'($urandom);
                if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << s) - 1);
                HBURST = 3'($urandom);
                push(d, t, 1'($urandom), s, a, $urandom);
            end
            run_seq(d);
        end

        // Final sweep of every word in both memories
        for (int d = 0; d < 2; d++) begin
            seq.delete();
            for (int k = 0; k < depth_w[d]; k++) push(d, 2'd2, 1'b0, 3'd2, 8'(4 * k), 32'h0);
            run_seq(d);
        end

        finish_now();
    end

endmodule
`default_nettype wire
